pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sat_cnt16.sv | 29 ++
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forwarding select codes, memory timeout and the forwarding-select rule.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [7:0] MEM_TIMEOUT = 8'd255;

    // The youngest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] exm_rd,
        input logic       exm_we,
        input logic [4:0] mwb_rd,
        input logic       mwb_we
    );
        if (exm_we && (exm_rd != 5'd0) && (exm_rd == rs)) begin
            return FWD_EXMEM;
        end else if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == rs)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter: increments on inc, holds at all-ones, async reset.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use stall,
// taken-branch flush and data-memory wait with a timeout watchdog.
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_mem_to_reg,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_regwrite,
    input  logic        ex_mem_dmem_req,
    input  logic [4:0]  mem_wb_rd,
    input  logic        mem_wb_regwrite,
    input  logic        branch_taken,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wait_cnt_d;
    logic        mem_err_q;
    logic        mem_err_d;
    logic        load_use;
    logic        mem_miss;
    logic        timeout;
    logic        br_flush;

    assign load_use = id_ex_mem_to_reg && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));
    assign mem_miss = ex_mem_dmem_req && !dmem_ready;
    // wait_cnt_q counts completed wait cycles, so this is the last allowed one.
    assign timeout  = (wait_cnt_q == (MEM_TIMEOUT - 8'd1));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        br_flush     = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_miss) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = 8'd0;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    br_flush    = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                // EX is frozen here, so branch and load-use are not acted on.
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            br_flush     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign fwd_a   = rst ? FWD_RF : fwd_sel(ex_rs1, ex_mem_rd, ex_mem_regwrite,
                                            mem_wb_rd, mem_wb_regwrite);
    assign fwd_b   = rst ? FWD_RF : fwd_sel(ex_rs2, ex_mem_rd, ex_mem_regwrite,
                                            mem_wb_rd, mem_wb_regwrite);
    assign mem_err = mem_err_q;

    sat_cnt16 u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!pc_en),
        .cnt (stall_cnt)
    );

    sat_cnt16 u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br_flush),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic        id_ex_mem_to_reg, ex_mem_regwrite, ex_mem_dmem_req;
    logic        mem_wb_regwrite, branch_taken, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .ex_mem_dmem_req(ex_mem_dmem_req),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes}
    localparam logic [7:0] NORM = 8'b11111_000;
    localparam logic [7:0] FRZ  = 8'b00001_001;
    localparam logic [7:0] BRN  = 8'b11111_110;
    localparam logic [7:0] LDU  = 8'b00111_010;
    localparam logic [7:0] RSTP = 8'b00000_111;

    wire [7:0] ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                      if_id_flush, id_ex_flush, mem_wb_flush};

    int vectors = 0;
    int errors  = 0;

    // Reference model: "waiting" flag plus number of wait-state cycles spent.
    bit         m_wait;
    bit         m_err;
    int         m_waited;
    int         m_stall;
    int         m_flush;
    logic [7:0] m_ctl;
    logic [1:0] m_fa, m_fb;
    logic       m_lu;

    always_comb begin
        m_fa = 2'b00;
        m_fb = 2'b00;
        if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == ex_rs1)      m_fa = 2'b01;
        else if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == ex_rs1) m_fa = 2'b10;
        if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == ex_rs2)      m_fb = 2'b01;
        else if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == ex_rs2) m_fb = 2'b10;
        m_lu = id_ex_mem_to_reg && id_ex_rd != 0 && (id_ex_rd == id_rs1 || id_ex_rd == id_rs2);
        if (rst) begin
            m_fa  = 2'b00;
            m_fb  = 2'b00;
            m_ctl = RSTP;
        end else if (m_wait) begin
            // Total frozen cycles per access are capped at 255 (first one is in RUN).
            m_ctl = (!dmem_ready && (m_waited + 2) <= 255) ? FRZ : NORM;
        end else if (ex_mem_dmem_req && !dmem_ready) begin
            m_ctl = FRZ;
        end else if (branch_taken) begin
            m_ctl = BRN;
        end else if (m_lu) begin
            m_ctl = LDU;
        end else begin
            m_ctl = NORM;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 0; m_err <= 0; m_waited <= 0; m_stall <= 0; m_flush <= 0;
        end else begin
            if (m_ctl[7] == 1'b0 && m_stall < 65535) m_stall <= m_stall + 1;
            if (m_ctl == BRN && m_flush < 65535)     m_flush <= m_flush + 1;
            if (m_wait) begin
                if (dmem_ready) m_wait <= 0;
                else if (m_ctl == NORM) begin
                    m_wait <= 0;
                    m_err  <= 1;
                end else m_waited <= m_waited + 1;
            end else if (ex_mem_dmem_req && !dmem_ready) begin
                m_wait   <= 1;
                m_waited <= 0;
            end
        end
    end

    task automatic zero_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; id_ex_rd = 0;
        ex_mem_rd = 0; mem_wb_rd = 0; id_ex_mem_to_reg = 0; ex_mem_regwrite = 0;
        ex_mem_dmem_req = 0; mem_wb_regwrite = 0; branch_taken = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        zero_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        zero_inputs();
        ex_rs1 = 5; ex_mem_rd = 5; ex_mem_regwrite = 1; ex_rs2 = 6;
        mem_wb_rd = 6; mem_wb_regwrite = 1; branch_taken = 1;
        @(negedge clk); #1;
        vectors++; if (ctl !== RSTP) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, RSTP); end
        vectors++; if ({fwd_a, fwd_b} !== 4'b0) begin errors++; $display("FAIL reset_fwd: got %b%b expected 0000", fwd_a, fwd_b); end
        vectors++; if ({stall_cnt, flush_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        vectors++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", mem_err); end
        rst = 1'b0;
        zero_inputs();
    endtask

    task automatic test_forwarding();
        do_reset();
        @(negedge clk);
        ex_rs1 = 5; ex_mem_rd = 5; ex_mem_regwrite = 1; mem_wb_rd = 5; mem_wb_regwrite = 1;
        #1;
        vectors++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_exmem: got %b expected 01", fwd_a); end
        @(negedge clk);
        ex_mem_rd = 0;
        #1;
        vectors++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_memwb: got %b expected 10", fwd_a); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_mem_rd = 5'($urandom_range(0, 3)); mem_wb_rd = 5'($urandom_range(0, 3));
            ex_mem_regwrite = 1'($urandom); mem_wb_regwrite = 1'($urandom);
            #1;
            vectors++; if ({fwd_a, fwd_b} !== {m_fa, m_fb}) begin errors++; $display("FAIL fwd_rand: got %b/%b expected %b/%b", fwd_a, fwd_b, m_fa, m_fb); end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        id_ex_mem_to_reg = 1; id_ex_rd = 3; id_rs2 = 3; id_rs1 = 7;
        #1;
        vectors++; if (ctl !== LDU) begin errors++; $display("FAIL load_use_ctl: got %b expected %b", ctl, LDU); end
        @(negedge clk);
        id_ex_mem_to_reg = 0;
        #1;
        vectors++; if (ctl !== NORM) begin errors++; $display("FAIL load_use_release: got %b expected %b", ctl, NORM); end
        vectors++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_mem_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ex_mem_dmem_req = 1; dmem_ready = (i == 4);
            #1;
            vectors++; if (ctl !== ((i < 4) ? FRZ : NORM)) begin errors++; $display("FAIL mem_stall_cyc%0d: got %b expected %b", i, ctl, (i < 4) ? FRZ : NORM); end
        end
        @(negedge clk);
        ex_mem_dmem_req = 0; dmem_ready = 0;
        #1;
        vectors++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL mem_stall_cnt: got %0d expected 4", stall_cnt); end
        vectors++; if (ctl !== NORM) begin errors++; $display("FAIL mem_stall_after: got %b expected %b", ctl, NORM); end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        branch_taken = 1; id_ex_mem_to_reg = 1; id_ex_rd = 4; id_rs1 = 4;
        #1;
        vectors++; if (ctl !== BRN) begin errors++; $display("FAIL branch_over_lu: got %b expected %b", ctl, BRN); end
        @(negedge clk);
        branch_taken = 0; id_ex_mem_to_reg = 0;
        #1;
        vectors++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL branch_flush_cnt: got %0d expected 1", flush_cnt); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_mem_dmem_req = 1; dmem_ready = (i == 3); branch_taken = 1;
            #1;
            vectors++; if (ctl !== ((i < 3) ? FRZ : NORM)) begin errors++; $display("FAIL branch_in_wait%0d: got %b expected %b", i, ctl, (i < 3) ? FRZ : NORM); end
        end
        @(negedge clk);
        zero_inputs();
        #1;
        vectors++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL branch_wait_flush_cnt: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_timeout();
        int  frozen;
        bit  released;
        frozen   = 0;
        released = 0;
        do_reset();
        for (int i = 0; i < 300 && !released; i++) begin
            @(negedge clk);
            ex_mem_dmem_req = 1; dmem_ready = 0;
            #1;
            vectors++; if (ctl !== m_ctl) begin errors++; $display("FAIL timeout_ctl%0d: got %b expected %b", i, ctl, m_ctl); end
            if (ctl == FRZ) frozen++;
            else released = 1;
        end
        vectors++; if (!released) begin errors++; $display("FAIL timeout_release: got none within 300 cycles expected release"); end
        vectors++; if (frozen != 255) begin errors++; $display("FAIL timeout_frozen: got %0d expected 255", frozen); end
        @(negedge clk);
        ex_mem_dmem_req = 0;
        #1;
        vectors++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", mem_err); end
        vectors++; if (ctl !== NORM) begin errors++; $display("FAIL timeout_run: got %b expected %b", ctl, NORM); end
        vectors++; if (stall_cnt !== 16'd255) begin errors++; $display("FAIL timeout_stall_cnt: got %0d expected 255", stall_cnt); end
        @(negedge clk);
        #1;
        vectors++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", mem_err); end
        do_reset();
        #1;
        vectors++; if (mem_err !== 1'b0) begin errors++; $display("FAIL err_clear_rst: got %b expected 0", mem_err); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_rs1 = 5; ex_mem_rd = 5; ex_mem_regwrite = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ex_mem_dmem_req = 1; dmem_ready = 0;
            #1;
            vectors++; if (ctl !== FRZ) begin errors++; $display("FAIL midwait_frz%0d: got %b expected %b", i, ctl, FRZ); end
        end
        #2 rst = 1'b1;
        #1;
        vectors++; if (ctl !== RSTP) begin errors++; $display("FAIL midwait_rst_ctl: got %b expected %b", ctl, RSTP); end
        vectors++; if ({fwd_a, stall_cnt, mem_err} !== 19'd0) begin errors++; $display("FAIL midwait_rst_state: got fwd %b stall %0d err %b expected 0", fwd_a, stall_cnt, mem_err); end
        @(negedge clk);
        rst = 1'b0; ex_mem_dmem_req = 0;
        #1;
        vectors++; if (ctl !== NORM) begin errors++; $display("FAIL midwait_run: got %b expected %b", ctl, NORM); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            id_ex_rd = 5'($urandom_range(0, 3)); ex_mem_rd = 5'($urandom_range(0, 3));
            mem_wb_rd = 5'($urandom_range(0, 3));
            id_ex_mem_to_reg = 1'($urandom); ex_mem_regwrite = 1'($urandom);
            mem_wb_regwrite = 1'($urandom);
            ex_mem_dmem_req = ($urandom_range(0, 3) == 0);
            dmem_ready = 1'($urandom);
            branch_taken = ($urandom_range(0, 4) == 0);
            #1;
            vectors++; if (ctl !== m_ctl) begin errors++; $display("FAIL rand_ctl%0d: got %b expected %b", i, ctl, m_ctl); end
            vectors++; if ({fwd_a, fwd_b} !== {m_fa, m_fb}) begin errors++; $display("FAIL rand_fwd%0d: got %b/%b expected %b/%b", i, fwd_a, fwd_b, m_fa, m_fb); end
            vectors++; if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin errors++; $display("FAIL rand_cnt%0d: got %0d/%0d expected %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush); end
            vectors++; if (mem_err !== m_err) begin errors++; $display("FAIL rand_err%0d: got %b expected %b", i, mem_err, m_err); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_stall();
        test_branch();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
